uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter p_requesters, default 4, is the number of byte-stream requesters sharing one UART transmitter (2..8).
REQ-002 Parameter p_gap, default 2, is the number of idle clk cycles forced between packets (0..255).
REQ-003 Parameter p_timeout, default 1024, is the number of stall cycles before a mid-packet grant is revoked; it is used only with the timeout feature.
REQ-004 Port clk, input, 1, is the single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1, is the asynchronous, active-high reset.
REQ-006 Port ip_valid, input, p_requesters, carries per-requester byte valid.
REQ-007 Port ip_last, input, p_requesters, carries per-requester last-byte-of-packet flag, qualified by ip_valid.
REQ-008 Port ip_data, input, 8*p_requesters, carries per-requester byte; requester k uses bits [8k+7:8k].
REQ-009 Port op_ready, output, p_requesters, carries per-requester byte accept.
REQ-010 Port orp_grant, output, p_requesters, is the registered one-hot current owner, all-zero when none.
REQ-011 Port o_tx_valid, output, 1, is byte valid to the transmitter.
REQ-012 Port o8_tx_data, output, 8, is the byte to the transmitter.
REQ-013 Port i_tx_ready, input, 1, means the transmitter accepts a byte this cycle.
REQ-014 Port or_timeout, output, 1, is a one-cycle pulse on grant revocation; it is constant 0 when the timeout feature is excluded.

Function
REQ-015 FSM states: ST_IDLE, ST_XFER, ST_GAP.
REQ-016 ST_IDLE: if any ip_valid is set, register orp_grant to the round-robin winner and enter ST_XFER next cycle; otherwise stay.
REQ-017 Round-robin search starts at the index after the last owner, wraps modulo p_requesters, and starts at index 0 after reset.
REQ-018 ST_XFER: o_tx_valid=ip_valid[g], o8_tx_data=ip_data[g], op_ready[g]=i_tx_ready (combinational, g=owner); all other op_ready bits are 0.
REQ-019 A byte transfers when o_tx_valid and i_tx_ready are both high; the transfer adds no latency beyond the one-cycle grant.
REQ-020 Transfer with ip_last[g]=1: clear orp_grant and enter ST_GAP; if p_gap=0, enter ST_IDLE instead.
REQ-021 ST_GAP: count p_gap cycles with all outputs inactive, then enter ST_IDLE.
REQ-022 Grant is held across the whole packet; requests arriving meanwhile wait; no preemption.
REQ-023 Deassertion of ip_valid[g] mid-packet keeps the grant (stall).
REQ-024 Outside ST_XFER: o_tx_valid=0, op_ready=0, o8_tx_data=0.
REQ-025 Single-byte packet (ip_last on first byte): ST_IDLE->ST_XFER->ST_GAP, one byte passed.

Reset
REQ-026 rst asynchronously forces ST_IDLE, orp_grant=0, round-robin pointer=0, gap counter=0, stall counter=0, or_timeout=0.
REQ-027 Reset mid-packet abandons the packet; no further byte of it is forwarded after reset release.

Configuration
REQ-028 Macro UART_TX_ARBITER_TIMEOUT_EN defined: in ST_XFER, count consecutive cycles without a transfer; the count resets to 0 on each transfer.
REQ-029 With UART_TX_ARBITER_TIMEOUT_EN defined, when the count reaches p_timeout: pulse or_timeout for one cycle, clear the grant, and enter ST_GAP.
REQ-030 Macro undefined: no counter is built, or_timeout is tied to 0, and a stall lasts indefinitely.

Structure
REQ-031 Shared package uart_pkg holds the FSM state encoding and byte-width constant (8).
REQ-032 Sub-module uart_rr_arbiter holds the combinational round-robin pick (request vector, pointer in; one-hot winner out).

Verification
REQ-033 Requester 2 sends 3 bytes 0x11,0x22,0x33 (last on 0x33), i_tx_ready=1 -> transmitter sees 0x11,0x22,0x33 consecutively; orp_grant=4'b0100; then 2 gap cycles.
REQ-034 All 4 requesters request 1-byte packets continuously -> grants rotate 0,1,2,3,0 with no starvation.
REQ-035 Requester 1 mid-packet, requester 0 raises valid -> requester 0 is granted only after requester 1's last byte plus the gap.
REQ-036 i_tx_ready low 10 cycles mid-packet -> o8_tx_data/o_tx_valid held stable, no byte lost or duplicated.
REQ-037 Timeout enabled, p_timeout=16, owner drops ip_valid -> or_timeout pulses at stall cycle 16 and the grant clears.
REQ-038 rst asserted mid-packet asynchronously -> orp_grant=0 immediately, the next grant goes to requester 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants for the UART transmit arbiter: FSM state encoding and byte width.
package uart_pkg;

  localparam int UART_BYTE_W = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_XFER = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

endpackage

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin pick: the first requester at or after i_ptr (wrapping) wins.
module uart_rr_arbiter #(
  parameter int  p_requesters = 4,
  localparam int PW           = $clog2(p_requesters)
) (
  input  logic [p_requesters-1:0] i_req,
  input  logic [PW-1:0]           i_ptr,
  output logic [p_requesters-1:0] o_grant
);

  logic [PW-1:0] idx;

  // Scan from the farthest offset down so the nearest requester overwrites the rest.
  always_comb begin
    o_grant = '0;
    idx     = '0;
    for (int off = p_requesters - 1; off >= 0; off--) begin
      idx = PW'((int'(i_ptr) + off) % p_requesters);
      if (i_req[idx]) begin
        o_grant      = '0;
        o_grant[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one UART transmitter among byte streams.
// Optional stall timeout with grant revocation: define UART_TX_ARBITER_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int p_requesters = 4,
  parameter int p_gap        = 2,
  parameter int p_timeout    = 1024
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [p_requesters-1:0]             ip_valid,
  input  logic [p_requesters-1:0]             ip_last,
  input  logic [UART_BYTE_W*p_requesters-1:0] ip_data,
  output logic [p_requesters-1:0]             op_ready,
  output logic [p_requesters-1:0]             orp_grant,
  output logic                                o_tx_valid,
  output logic [UART_BYTE_W-1:0]              o8_tx_data,
  input  logic                                i_tx_ready,
  output logic                                or_timeout
);

  localparam int         PW       = $clog2(p_requesters);
  localparam logic [7:0] GAP_LAST = (p_gap > 0) ? 8'(p_gap - 1) : 8'd0;

  logic [1:0]              st_q, st_d;
  logic [p_requesters-1:0] grant_q, grant_d;
  logic [p_requesters-1:0] rr_win;
  logic [PW-1:0]           ptr_q, ptr_d;
  logic [7:0]              gap_q, gap_d;
  logic                    sel_valid, sel_last;
  logic [UART_BYTE_W-1:0]  sel_data;
  logic                    in_xfer, xfer, xfer_last, stall_expired;

  uart_rr_arbiter #(
    .p_requesters(p_requesters)
  ) u_rr (
    .i_req  (ip_valid),
    .i_ptr  (ptr_q),
    .o_grant(rr_win)
  );

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int k = 0; k < p_requesters; k++) begin
      if (grant_q[k]) begin
        sel_valid = ip_valid[k];
        sel_last  = ip_last[k];
        sel_data  = ip_data[k*UART_BYTE_W +: UART_BYTE_W];
      end
    end
  end

  assign in_xfer    = (st_q == ST_XFER);
  assign o_tx_valid = in_xfer & sel_valid;
  assign o8_tx_data = in_xfer ? sel_data : '0;
  assign op_ready   = in_xfer ? (grant_q & {p_requesters{i_tx_ready}}) : '0;
  assign orp_grant  = grant_q;
  assign xfer       = o_tx_valid & i_tx_ready;
  assign xfer_last  = xfer & sel_last;

`ifdef UART_TX_ARBITER_TIMEOUT_EN
  localparam int            TW       = $clog2(p_timeout + 1);
  localparam logic [TW-1:0] TO_LIMIT = TW'(p_timeout);

  logic [TW-1:0] stall_q, stall_d;
  logic          timeout_q, timeout_d;

  assign stall_expired = in_xfer && !xfer && ((stall_q + 1'b1) == TO_LIMIT);

  always_comb begin
    stall_d   = '0;
    timeout_d = stall_expired;
    if (in_xfer && !xfer && !stall_expired) stall_d = stall_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      stall_q   <= stall_d;
      timeout_q <= timeout_d;
    end
  end

  assign or_timeout = timeout_q;
`else
  assign stall_expired = 1'b0;
  // Always low here; p_timeout only sizes the optional stall counter.
  assign or_timeout    = (p_timeout < 0);
`endif

  always_comb begin
    st_d    = st_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    gap_d   = gap_q;
    case (st_q)
      ST_IDLE: begin
        if (|ip_valid) begin
          grant_d = rr_win;
          st_d    = ST_XFER;
          for (int k = 0; k < p_requesters; k++) begin
            if (rr_win[k]) ptr_d = PW'((k + 1) % p_requesters);
          end
        end
      end
      ST_XFER: begin
        if (xfer_last || stall_expired) begin
          grant_d = '0;
          gap_d   = '0;
          st_d    = (p_gap == 0) ? ST_IDLE : ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d = '0;
          st_d  = ST_IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: begin
        st_d    = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q    <= ST_IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      gap_q   <= '0;
    end else begin
      st_q    <= st_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      gap_q   <= gap_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: vector table, corner sequences, randomized model run.
module tb_uart_tx_arbiter;

  localparam int N   = 4;
  localparam int GAP = 2;
  localparam int TO  = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] ip_valid = '0;
  logic [N-1:0] ip_last = '0;
  logic [8*N-1:0] ip_data = '0;
  logic [N-1:0] op_ready;
  logic [N-1:0] orp_grant;
  logic         o_tx_valid;
  logic [7:0]   o8_tx_data;
  logic         i_tx_ready = 1'b0;
  logic         or_timeout;

  int n_checks = 0;
  int n_fail   = 0;
  int hs_cnt   = 0;

  uart_tx_arbiter #(
    .p_requesters(N),
    .p_gap       (GAP),
    .p_timeout   (TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ip_valid  (ip_valid),
    .ip_last   (ip_last),
    .ip_data   (ip_data),
    .op_ready  (op_ready),
    .orp_grant (orp_grant),
    .o_tx_valid(o_tx_valid),
    .o8_tx_data(o8_tx_data),
    .i_tx_ready(i_tx_ready),
    .or_timeout(or_timeout)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && o_tx_valid && i_tx_ready) hs_cnt <= hs_cnt + 1;
  end

  typedef struct {
    logic [N-1:0]   valid;
    logic [N-1:0]   last;
    logic [8*N-1:0] data;
    logic           txr;
    logic [N-1:0]   e_grant;
    logic [N-1:0]   e_ready;
    logic           e_valid;
    logic [7:0]     e_data;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    ip_valid   = '0;
    ip_last    = '0;
    ip_data    = '0;
    i_tx_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Waits (bounded) for the first non-zero grant and compares it; returns at that negedge.
  task automatic wait_any(input string name, input logic [N-1:0] exp);
    int n;
    n = 0;
    @(negedge clk);
    while (orp_grant == '0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(orp_grant), 32'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, required completion before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int   got, n, ridx, owner, gap_left, ptr, remaining;
    bit   stable, found;
    int   base;
    logic [7:0] bq [N][$];
    bit         lq [N][$];

    vecs[0] = '{4'b0100, 4'b0000, 32'h0011_0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 8'h00};
    vecs[1] = '{4'b0100, 4'b0000, 32'h0011_0000, 1'b1, 4'b0100, 4'b0100, 1'b1, 8'h11};
    vecs[2] = '{4'b0100, 4'b0000, 32'h0022_0000, 1'b1, 4'b0100, 4'b0100, 1'b1, 8'h22};
    vecs[3] = '{4'b0100, 4'b0100, 32'h0033_0000, 1'b1, 4'b0100, 4'b0100, 1'b1, 8'h33};
    vecs[4] = '{4'b0000, 4'b0000, 32'h0000_0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 8'h00};
    vecs[5] = '{4'b0000, 4'b0000, 32'h0000_0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 8'h00};
    vecs[6] = '{4'b0001, 4'b0001, 32'h0000_005A, 1'b1, 4'b0000, 4'b0000, 1'b0, 8'h00};
    vecs[7] = '{4'b0001, 4'b0001, 32'h0000_005A, 1'b1, 4'b0001, 4'b0001, 1'b1, 8'h5A};
    vecs[8] = '{4'b0000, 4'b0000, 32'h0000_0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 8'h00};

    // Reset state
    @(negedge clk);
    check("reset_state", {orp_grant, op_ready, o_tx_valid, o8_tx_data, or_timeout}, 32'h0);

    // Vector table: 3-byte packet from requester 2, 2-cycle gap, then requester 0
    do_reset();
    for (int i = 0; i < 9; i++) begin
      ip_valid   = vecs[i].valid;
      ip_last    = vecs[i].last;
      ip_data    = vecs[i].data;
      i_tx_ready = vecs[i].txr;
      @(negedge clk);
      $display("vec%0d grant=%b ready=%b tx_valid=%b data=%h", i, orp_grant, op_ready,
               o_tx_valid, o8_tx_data);
      check($sformatf("vec%0d", i), {orp_grant, op_ready, o_tx_valid, o8_tx_data},
            {vecs[i].e_grant, vecs[i].e_ready, vecs[i].e_valid, vecs[i].e_data});
      @(posedge clk);
      #1;
    end

    // Rotation with all requesters sending 1-byte packets
    do_reset();
    ip_valid   = 4'b1111;
    ip_last    = 4'b1111;
    ip_data    = 32'h4433_2211;
    i_tx_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 60 && got < 5; c++) begin
      @(negedge clk);
      if (orp_grant != '0) begin
        ridx = got % N;
        $display("rotation grant %0d -> %b byte %h", got, orp_grant, o8_tx_data);
        check($sformatf("rot%0d", got), {orp_grant, o8_tx_data},
              {4'(1 << ridx), 8'(8'h11 * (ridx + 1))});
        got++;
      end
    end
    if (got < 5) check("rot_count", got, 5);

    // Requester 0 waits for requester 1's packet plus the gap
    do_reset();
    ip_valid   = 4'b0010;
    ip_data    = 32'h0000_A100;
    i_tx_ready = 1'b1;
    wait_any("mid_grant", 4'b0010);
    @(posedge clk); #1;
    ip_valid = 4'b0011;
    ip_last  = 4'b0001;
    ip_data  = 32'h0000_A20B;
    @(negedge clk);
    check("mid_hold1", {orp_grant, o8_tx_data}, {4'b0010, 8'hA2});
    @(posedge clk); #1;
    ip_last = 4'b0011;
    ip_data = 32'h0000_A30B;
    @(negedge clk);
    check("mid_hold2", {orp_grant, o8_tx_data}, {4'b0010, 8'hA3});
    @(posedge clk); #1;
    ip_valid = 4'b0001;
    ip_last  = 4'b0001;
    n = 0;
    found = 0;
    while (!found && n < 12) begin
      @(negedge clk);
      n++;
      if (orp_grant == 4'b0001) found = 1;
    end
    $display("requester 0 granted %0d cycles after requester 1 last byte", n);
    check("mid_wait", n, GAP + 2);
    check("mid_req0_data", {o_tx_valid, o8_tx_data}, {1'b1, 8'h0B});

    // Transmitter stall for 10 cycles mid-packet
    do_reset();
    ip_valid   = 4'b0100;
    ip_data    = 32'h00C1_0000;
    i_tx_ready = 1'b1;
    base = hs_cnt;
    wait_any("stall_grant", 4'b0100);
    @(posedge clk); #1;
    ip_data    = 32'h00C2_0000;
    ip_last    = 4'b0100;
    i_tx_ready = 1'b0;
    stable = 1;
    repeat (10) begin
      @(negedge clk);
      if (!(o_tx_valid === 1'b1 && o8_tx_data === 8'hC2 && op_ready === 4'b0000 &&
            orp_grant === 4'b0100)) stable = 0;
      @(posedge clk); #1;
    end
    check("stall_hold", stable, 1);
    i_tx_ready = 1'b1;
    @(negedge clk);
    check("stall_release", {op_ready, o_tx_valid, o8_tx_data}, {4'b0100, 1'b1, 8'hC2});
    @(posedge clk); #1;
    ip_data = 32'h00C3_0000;
    @(negedge clk);
    check("stall_gap", {orp_grant, o_tx_valid}, 32'h0);
    check("stall_bytes", hs_cnt - base, 2);
    $display("stall packet forwarded %0d bytes", hs_cnt - base);

    // Asynchronous reset mid-packet, then round-robin restarts at requester 0
    do_reset();
    ip_valid   = 4'b0010;
    ip_data    = 32'h0000_D100;
    i_tx_ready = 1'b1;
    wait_any("rst_grant", 4'b0010);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("rst_async", {orp_grant, o_tx_valid, op_ready}, 32'h0);
    ip_valid = 4'b1001;
    ip_last  = 4'b1001;
    ip_data  = 32'hE300_00E0;
    @(posedge clk);
    #1 rst = 1'b0;
    wait_any("rst_rr0", 4'b0001);
    check("rst_rr0_data", o8_tx_data, 8'hE0);

`ifdef UART_TX_ARBITER_TIMEOUT_EN
    // Owner drops valid; grant is revoked after the stall limit
    do_reset();
    ip_valid   = 4'b0100;
    ip_data    = 32'h00C1_0000;
    i_tx_ready = 1'b1;
    wait_any("to_grant", 4'b0100);
    @(posedge clk); #1;
    ip_valid = 4'b0000;
    n = 0;
    found = 0;
    while (!found && n < 40) begin
      @(negedge clk);
      n++;
      if (or_timeout) found = 1;
    end
    $display("timeout pulse %0d cycles after last transfer", n);
    check("to_cycle", n, TO + 1);
    check("to_grant_clr", orp_grant, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("to_pulse", or_timeout, 0);
`endif

    // Randomized traffic against a timestamp-level reference model
    do_reset();
    for (int k = 0; k < N; k++) begin
      int npk;
      npk = 1 + int'($urandom_range(3));
      for (int p = 0; p < npk; p++) begin
        int len;
        len = 1 + int'($urandom_range(3));
        for (int b = 0; b < len; b++) begin
          bq[k].push_back(8'($urandom));
          lq[k].push_back(b == len - 1);
        end
      end
    end
    owner    = -1;
    gap_left = 0;
    ptr      = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic [N-1:0] eg, er;
      logic         ev;
      logic [7:0]   ed;
      for (int k = 0; k < N; k++) begin
        ip_valid[k] = (bq[k].size() > 0) && ($urandom_range(3) != 0);
        ip_data[k*8 +: 8] = (bq[k].size() > 0) ? bq[k][0] : 8'($urandom);
        ip_last[k] = (lq[k].size() > 0) ? lq[k][0] : 1'($urandom);
      end
      i_tx_ready = ($urandom_range(3) != 0);
      @(negedge clk);
      eg = '0; er = '0; ev = 1'b0; ed = 8'h00;
      if (owner >= 0) begin
        eg = 4'(1 << owner);
        ev = ip_valid[owner];
        ed = bq[owner][0];
        er = i_tx_ready ? eg : '0;
      end
      check($sformatf("rand_c%0d", cyc), {orp_grant, op_ready, o_tx_valid, o8_tx_data},
            {eg, er, ev, ed});
      if (owner >= 0) begin
        if (ip_valid[owner] && i_tx_ready) begin
          void'(bq[owner].pop_front());
          if (lq[owner].pop_front()) begin
            $display("rand packet from requester %0d done at cycle %0d", owner, cyc);
            owner    = -1;
            gap_left = GAP;
          end
        end
      end else if (gap_left > 0) begin
        gap_left--;
      end else if (ip_valid != '0) begin
        for (int i = N - 1; i >= 0; i--) begin
          if (ip_valid[(ptr + i) % N]) owner = (ptr + i) % N;
        end
        ptr = (owner + 1) % N;
      end
      remaining = 0;
      for (int k = 0; k < N; k++) remaining += bq[k].size();
      @(posedge clk); #1;
      if (remaining == 0 && owner < 0 && gap_left == 0) break;
    end
    remaining = 0;
    for (int k = 0; k < N; k++) remaining += bq[k].size();
    check("rand_drain", remaining, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
